// File: rtl/rgb_pwm_driver_pkg.sv
// Shared constants, types and helpers for the RGB PWM driver slice.
package rgb_pwm_driver_pkg;

  localparam int RGB_R = 0;
  localparam int RGB_G = 1;
  localparam int RGB_B = 2;
  localparam int COLOURS_PER_LED  = 3;
  localparam int DEFAULT_PWM_BITS = 4;

  typedef enum logic {
    BLINK_ON  = 1'b0,
    BLINK_OFF = 1'b1
  } blink_state_t;

  // Counter widths never collapse to zero bits, even for a count of 1.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int nch_of(input int num_leds);
    return COLOURS_PER_LED * num_leds;
  endfunction

endpackage

// File: rtl/rgb_pwm_driver_if.sv
// Duty write port: single-cycle strobe, channel index and duty value, no backpressure.
interface rgb_pwm_driver_if #(
  parameter int NCH      = 6,
  parameter int PWM_BITS = 4
);
  import rgb_pwm_driver_pkg::*;

  localparam int CHAN_W = clog2_min1(NCH);

  logic                wr_en;
  logic [CHAN_W-1:0]   wr_chan;
  logic [PWM_BITS-1:0] wr_duty;

  modport master (output wr_en, output wr_chan, output wr_duty);
  modport slave  (input  wr_en, input  wr_chan, input  wr_duty);

endinterface

// File: rtl/rgb_pwm_driver_channel.sv
// rgb_pwm_channel: staging/active duty registers and registered PWM compare for one colour channel.
module rgb_pwm_channel #(
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_hit,
  input  logic [PWM_BITS-1:0] wr_duty,
  input  logic                boundary,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                sw_bit,
  input  logic                blink_on,
  output logic                led
);

  logic [PWM_BITS-1:0] staging_q, staging_d;
  logic [PWM_BITS-1:0] active_q, active_d;
  logic                led_q, led_d;

  // Active copies the pre-write staging value, so a write landing on the boundary waits a period.
  always_comb begin
    staging_d = staging_q;
    active_d  = active_q;
    if (boundary) begin
      active_d = staging_q;
    end
    if (wr_hit) begin
      staging_d = wr_duty;
    end
    led_d = sw_bit & (pwm_cnt < active_q) & blink_on;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      staging_q <= '0;
      active_q  <= '0;
      led_q     <= 1'b0;
    end else begin
      staging_q <= staging_d;
      active_q  <= active_d;
      led_q     <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver: PWM driver for NUM_LEDS RGB LEDs with switch gating and a duty write port.
// Define RGB_BLINK_EN to add the blink_en port and the ON/OFF blink FSM.
module rgb_pwm_driver
  import rgb_pwm_driver_pkg::*;
#(
  parameter int NUM_LEDS      = 2,
  parameter int PWM_BITS      = DEFAULT_PWM_BITS,
  parameter int PRESCALE      = 1000,
  parameter int BLINK_PERIODS = 50
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [COLOURS_PER_LED*NUM_LEDS-1:0] sw,
  rgb_pwm_driver_if.slave                     wr,
`ifdef RGB_BLINK_EN
  input  logic                                blink_en,
`endif
  output logic [COLOURS_PER_LED*NUM_LEDS-1:0] led_out,
  output logic                                period_start
);

  localparam int NCH    = nch_of(NUM_LEDS);
  localparam int CHAN_W = clog2_min1(NCH);
  localparam int MAX    = (2 ** PWM_BITS) - 1;
  localparam int PS_W   = clog2_min1(PRESCALE);

  localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'(MAX - 1);

  if (PRESCALE < 1 || BLINK_PERIODS < 1) begin : g_param_check
    $error("rgb_pwm_driver: PRESCALE and BLINK_PERIODS must be >= 1");
  end

  logic [PS_W-1:0]     presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                period_start_q, period_start_d;
  logic                tick;
  logic                boundary;
  logic                blink_on;

  // The period is MAX ticks (0..MAX-1) so a duty of MAX stays high across the wrap.
  always_comb begin
    tick           = (presc_q == PS_LAST);
    presc_d        = tick ? '0 : presc_q + 1'b1;
    boundary       = tick && (pwm_cnt_q == CNT_LAST);
    pwm_cnt_d      = pwm_cnt_q;
    if (tick) begin
      pwm_cnt_d = (pwm_cnt_q == CNT_LAST) ? '0 : pwm_cnt_q + 1'b1;
    end
    period_start_d = boundary;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q        <= '0;
      pwm_cnt_q      <= '0;
      period_start_q <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      pwm_cnt_q      <= pwm_cnt_d;
      period_start_q <= period_start_d;
    end
  end

  assign period_start = period_start_q;

`ifdef RGB_BLINK_EN
  localparam int BLINK_W = clog2_min1(BLINK_PERIODS);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_PERIODS - 1);

  blink_state_t        blink_state_q, blink_state_d;
  logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;

  always_comb begin
    blink_state_d = blink_state_q;
    blink_cnt_d   = blink_cnt_q;
    if (!blink_en) begin
      blink_state_d = BLINK_ON;
      blink_cnt_d   = '0;
    end else if (boundary) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        unique case (blink_state_q)
          BLINK_ON:  blink_state_d = BLINK_OFF;
          BLINK_OFF: blink_state_d = BLINK_ON;
          default:   blink_state_d = BLINK_ON;
        endcase
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_state_q <= BLINK_ON;
      blink_cnt_q   <= '0;
    end else begin
      blink_state_q <= blink_state_d;
      blink_cnt_q   <= blink_cnt_d;
    end
  end

  // Dropping blink_en releases the outputs immediately rather than waiting for the FSM.
  assign blink_on = (blink_state_q == BLINK_ON) || !blink_en;
`else
  assign blink_on = 1'b1;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    rgb_pwm_channel #(
      .PWM_BITS (PWM_BITS)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_hit   (wr.wr_en && (wr.wr_chan == CHAN_W'(i))),
      .wr_duty  (wr.wr_duty),
      .boundary (boundary),
      .pwm_cnt  (pwm_cnt_q),
      .sw_bit   (sw[i]),
      .blink_on (blink_on),
      .led      (led_out[i])
    );
  end

endmodule
